// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions.
// Contents:
//   - XLEN_DEFAULT: default datapath width.
//   - OPC_*: base-ISA major opcodes.
//   - imm_type_e: immediate format classes.
//   - imm_type_of(): maps an opcode to its immediate format class.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm_type_of = IMM_I;
      OPC_STORE:                      imm_type_of = IMM_S;
      OPC_BRANCH:                     imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type_of = IMM_U;
      OPC_JAL:                        imm_type_of = IMM_J;
      default:                        imm_type_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_operand_stage_imm_gen.sv
// Combinational immediate generator.
// Ports:
//   instr (in, 32)  : instruction word.
//   imm   (out, XLEN): sign-extended immediate; 0 for formats without one.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_type_e   imm_type_s;
  logic [31:0] imm32_s;

  // Classify the instruction's immediate format from its opcode.
  always_comb begin
    imm_type_s = imm_type_of(instr[6:0]);
  end

  // Reassemble the scattered immediate bits into a 32-bit value.
  always_comb begin
    case (imm_type_s)
      IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32_s = {instr[31:12], 12'b0};
      IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'b0;
    endcase
  end

  // Signed cast so that a wider XLEN still sign-extends.
  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage feeding the ID/EX pipeline register.
// Ports:
//   clk, rst                  : clock, async active-high reset.
//   in_valid/in_ready         : IF/ID handshake.
//   in_instr, in_pc           : incoming instruction and its PC.
//   rf_a1/rf_a2               : register file read addresses.
//   rf_rd1/rf_rd2             : register file read data.
//   ex_*                      : EX stage load info for the load-use check.
//   mem_*/wb_*                : forwarding sources.
//   flush                     : kills ID and the ID/EX bundle.
//   out_valid/out_ready       : ID/EX handshake.
//   out_*                     : registered ID/EX bundle.
//   stall_cnt                 : saturating count of load-use bubbles.
// The register file does not hard-wire x0 and writes on the clock edge, so
// this stage forces x0 to zero and bypasses the WB write itself.
module id_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic [4:0]             rf_a1,
  output logic [4:0]             rf_a2,
  input  logic [XLEN-1:0]        rf_rd1,
  input  logic [XLEN-1:0]        rf_rd2,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   mem_we,
  input  logic [4:0]             mem_rd,
  input  logic [XLEN-1:0]        mem_result,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_rs1_val,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [XLEN-1:0]        out_imm,
  output logic [4:0]             out_rd,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic                   out_funct7b5,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [6:0]             opcode_s;
  logic [4:0]             rs1_s, rs2_s, rd_s;
  logic                   uses_rs1_s, uses_rs2_s, has_rd_s;
  logic [XLEN-1:0]        imm_s, rs1_val_s, rs2_val_s;
  logic                   hazard_s, ready_s, slot_free_s;

  logic                   valid_d, valid_q;
  logic [XLEN-1:0]        pc_d, pc_q, rs1_val_d, rs1_val_q, rs2_val_d, rs2_val_q, imm_d, imm_q;
  logic [4:0]             rd_d, rd_q;
  logic [6:0]             opcode_d, opcode_q;
  logic [2:0]             funct3_d, funct3_q;
  logic                   funct7b5_d, funct7b5_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign opcode_s = in_instr[6:0];
  assign rs1_s    = in_instr[19:15];
  assign rs2_s    = in_instr[24:20];
  assign rd_s     = in_instr[11:7];
  assign rf_a1    = rs1_s;
  assign rf_a2    = rs2_s;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm_s)
  );

  // Which source registers the instruction reads and whether it writes rd.
  always_comb begin
    case (opcode_s)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        has_rd_s   = (opcode_s == OPC_OP);
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
        has_rd_s   = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        has_rd_s   = 1'b1;
      end
      default: begin
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        has_rd_s   = 1'b0;
      end
    endcase
  end

  // Operand select: x0, then the younger MEM result, then WB, then the RF.
  always_comb begin
    if (rs1_s == 5'd0) begin
      rs1_val_s = {XLEN{1'b0}};
    end else if (mem_we && (mem_rd == rs1_s)) begin
      rs1_val_s = mem_result;
    end else if (wb_we && (wb_rd == rs1_s)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = rf_rd1;
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = {XLEN{1'b0}};
    end else if (mem_we && (mem_rd == rs2_s)) begin
      rs2_val_s = mem_result;
    end else if (wb_we && (wb_rd == rs2_s)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = rf_rd2;
    end
  end

  // Load-use hazard and input handshake.
  always_comb begin
    hazard_s    = in_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1_s && (ex_rd == rs1_s)) || (uses_rs2_s && (ex_rd == rs2_s)));
    slot_free_s = !valid_q || out_ready;
    ready_s     = !hazard_s && !flush && slot_free_s;
  end

  assign in_ready = ready_s;

  // Next-state of the ID/EX bundle; flush wins, then capture, then bubble.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7b5_d  = funct7b5_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && ready_s) begin
      valid_d    = 1'b1;
      pc_d       = in_pc;
      rs1_val_d  = rs1_val_s;
      rs2_val_d  = rs2_val_s;
      imm_d      = imm_s;
      rd_d       = has_rd_s ? rd_s : 5'd0;
      opcode_d   = opcode_s;
      funct3_d   = in_instr[14:12];
      funct7b5_d = in_instr[30];
    end else if (hazard_s && slot_free_s) begin
      valid_d = 1'b0;
      if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= {XLEN{1'b0}};
      rs1_val_q   <= {XLEN{1'b0}};
      rs2_val_q   <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      rd_q        <= 5'd0;
      opcode_q    <= 7'd0;
      funct3_q    <= 3'd0;
      funct7b5_q  <= 1'b0;
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7b5_q  <= funct7b5_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1_val  = rs1_val_q;
  assign out_rs2_val  = rs2_val_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the 32x32 register file.
- Drives the register-file read addresses from the incoming instruction and forwards operands from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, generates immediates and registers the ID/EX pipeline bundle under a valid/ready handshake.
- Exists because the register file writes on the clock edge, reads combinationally and does not hard-wire x0.

Parameters:
- XLEN, 32, data width of PC, operands and immediate
- STALL_CNT_W, 16, width of the saturating load-use stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rf_a1  out  5  register file read address 1, equal to in_instr[19:15]
- rf_a2  out  5  register file read address 2, equal to in_instr[24:20]
- rf_rd1  in  XLEN  register file read data 1
- rf_rd2  in  XLEN  register file read data 2
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- mem_we  in  1  MEM stage will write back
- mem_rd  in  5  MEM destination register
- mem_result  in  XLEN  MEM forwardable result
- wb_we  in  1  WB stage is writing the register file this cycle
- wb_rd  in  5  WB destination register
- wb_data  in  XLEN  WB write data
- flush  in  1  branch/jump redirect; kill ID and the ID/EX bundle
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  EX accepts the bundle
- out_pc  out  XLEN  registered PC
- out_rs1_val  out  XLEN  registered operand 1
- out_rs2_val  out  XLEN  registered operand 2
- out_imm  out  XLEN  registered sign-extended immediate
- out_rd  out  5  registered rd (0 if the instruction has no rd)
- out_opcode  out  7  registered opcode
- out_funct3  out  3  registered funct3
- out_funct7b5  out  1  registered instr[30]
- stall_cnt  out  STALL_CNT_W  count of load-use stall cycles, saturating

Behaviour:
- Reset (rst=1, async): all out_* registers and stall_cnt are 0, out_valid is 0. Mid-operation reset drops the bundle in flight with no partial state.
- Decode and read-port use:
  - uses_rs1: JALR, LOAD, OP-IMM, OP, STORE, BRANCH.
  - uses_rs2: OP, STORE, BRANCH.
  - LUI, AUIPC and JAL use neither. Unknown opcodes use neither and get out_rd=0.
- Immediate generation:
  - I-type: JALR, LOAD, OP-IMM.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - All immediates are sign-extended to XLEN; all other opcodes give 0.
- Operand select, per source register, highest priority first:
  1. rs==0 gives 0.
  2. mem_we and mem_rd==rs gives mem_result.
  3. wb_we and wb_rd==rs gives wb_data.
  4. Otherwise the register file data.
- Load-use hazard:
  - Condition: in_valid && ex_valid && ex_is_load && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Register update, single cycle latency, evaluated in this priority order:
  1. flush: out_valid goes to 0 next edge and nothing is captured.
  2. in_valid && in_ready: capture the full bundle and set out_valid=1.
  3. hazard && (!out_valid || out_ready): insert a bubble (out_valid=0) and increment stall_cnt.
  4. out_valid && out_ready with no new input: out_valid goes to 0.
  5. Otherwise: hold every out_* register unchanged (backpressure).
- Bundle stability: while out_valid && !out_ready, the bundle is stable regardless of rf or forwarding inputs.
- stall_cnt saturates at all-ones and never wraps.
- Simultaneous events:
  - Flush together with a hazard: no count increment.
  - Forwarding is sampled only on the capture cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: LOAD=0000011, OP_IMM=0010011, AUIPC=0010111, STORE=0100011, OP=0110011, LUI=0110111, BRANCH=1100011, JALR=1100111, JAL=1101111.
  - imm_type enum.
  - the XLEN default.
- One natural sub-module: imm_gen, purely combinational (instr in, imm out).

Test Plan:
- WB bypass: instruction 0x002081B3 (add x3,x1,x2), rf_rd1=5, rf_rd2=7, wb_we=1, wb_rd=2, wb_data=9 -> next cycle out_rs1_val=5, out_rs2_val=9, out_rd=3, out_valid=1.
- MEM beats WB: mem_we=1, mem_rd=1, mem_result=0x11 and wb_we=1, wb_rd=1, wb_data=0x22 for rs1=x1 -> out_rs1_val=0x11.
- x0 source: instruction reads x0 with rf_rd1=0xDEAD, mem_we=1, mem_rd=0 -> out_rs1_val=0.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=1, incoming add uses x1 -> in_ready=0 for that cycle, bubble out_valid=0, stall_cnt 0->1; ex_valid drops -> captured next cycle.
- Backpressure then flush: hold out_ready=0 for 3 cycles -> bundle constant; assert flush -> out_valid=0 next cycle and the new in_instr is not captured.
- Immediates and reset: sw (imm=-4) gives out_imm=0xFFFFFFFC; jal with imm=+2048 gives 0x00000800; async rst mid-transfer gives out_valid=0 immediately.
